panel_power_seq: RTL and testbench

PANEL_POWER_SEQ -- requirements
Module: panel_power_seq

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/bl_pwm.sv | 78 +++++++
 rtl/panel_power_seq.sv | 162 ++++++++++++++++
 tb/tb_panel_power_seq.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD panel subsystem: the power sequencer state
// encoding and the default timing/PWM constants (also used by the timing
// generator).
// ----------------------------------------------------------------------------
package lcd_pkg;

    // Power sequencer state codes; the numeric values are visible on the
    // sequencer's state output and must stay fixed.
    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StWaitLock = 3'd1,
        StLinkUp   = 3'd2,
        StOn       = 3'd3,
        StBlDown   = 3'd4,
        StLinkDown = 3'd5
    } seq_state_e;

    // Defaults at a 100 MHz clock.
    localparam int unsigned DEF_T_LINK_TO_BL = 20_000_000;  // 200 ms
    localparam int unsigned DEF_T_BL_TO_LINK = 20_000_000;  // 200 ms
    localparam int unsigned DEF_T_MIN_OFF    = 50_000_000;  // 500 ms
    localparam int unsigned DEF_PWM_PRESCALE = 390;         // ~1 kHz PWM

    // Timer load value for a state lasting `cycles` clocks. The state exits
    // on the cycle the count reaches 0, so N cycles loads N-1.
    function automatic logic [31:0] timer_load(input int unsigned cycles);
        return (cycles == 0) ? 32'd0 : 32'(cycles - 1);
    endfunction

endpackage

// File: rtl/bl_pwm.sv
// ----------------------------------------------------------------------------
// bl_pwm
// Backlight PWM generator. An 8-bit counter advances once every PWM_PRESCALE
// clocks; output is high while cnt < duty. Duty is captured on run entry and
// thereafter only when cnt wraps, so brightness changes never glitch a period.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   run        - enable; counter, prescaler and duty held at 0 while low
//   brightness - requested duty (0 = off, 255 = 255/256)
//   pwm_out    - registered PWM output
// ----------------------------------------------------------------------------
module bl_pwm
    import lcd_pkg::*;
#(
    parameter int unsigned PWM_PRESCALE = DEF_PWM_PRESCALE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] brightness,
    output logic       pwm_out
);

    logic        r_active;
    logic [31:0] r_pre;
    logic [7:0]  r_cnt;
    logic [7:0]  r_duty;
    logic        r_pwm;

    logic [31:0] w_pre_d;
    logic [7:0]  w_cnt_d;
    logic [7:0]  w_duty_d;
    logic        w_pwm_d;

    always_comb begin
        w_pre_d  = 32'd0;
        w_cnt_d  = 8'd0;
        w_duty_d = 8'd0;
        if (run && !r_active) begin
            // First cycle of a run: start the period from zero with fresh duty.
            w_duty_d = brightness;
        end else if (run) begin
            w_pre_d  = r_pre + 32'd1;
            w_cnt_d  = r_cnt;
            w_duty_d = r_duty;
            if ((r_pre + 32'd1) >= 32'(PWM_PRESCALE)) begin
                w_pre_d = 32'd0;
                w_cnt_d = r_cnt + 8'd1;
                if (r_cnt == 8'hFF) begin
                    w_duty_d = brightness;
                end
            end
        end
        // Compare against next-state values so pwm_out tracks cnt with no lag.
        w_pwm_d = run && (w_cnt_d < w_duty_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_pre    <= 32'd0;
            r_cnt    <= 8'd0;
            r_duty   <= 8'd0;
            r_pwm    <= 1'b0;
        end else begin
            r_active <= run;
            r_pre    <= w_pre_d;
            r_cnt    <= w_cnt_d;
            r_duty   <= w_duty_d;
            r_pwm    <= w_pwm_d;
        end
    end

    assign pwm_out = r_pwm;

endmodule

// File: rtl/panel_power_seq.sv
// ----------------------------------------------------------------------------
// panel_power_seq
// LCD panel power sequencer: brings up the video link, waits for the panel to
// settle, enables the backlight, and reverses the order on power-down with a
// minimum off time. Lock loss of the serializer PLL forces an immediate
// shutdown and latches a fault until the request is withdrawn.
//
// Ports:
//   clk        - 100 MHz clock, rising edge
//   rst_n      - asynchronous active-low reset (deassertion pre-synchronized)
//   panel_on   - level request to power the panel
//   pll_locked - serializer MMCM lock
//   brightness - backlight duty (0 = off, 255 = 255/256)
//   video_en   - releases the timing generator and serializer
//   led_en     - backlight driver enable
//   led_pwm    - backlight PWM
//   ready      - high only in the ON state
//   fault      - sticky lock-loss flag
//   state      - current FSM state code
// ----------------------------------------------------------------------------
module panel_power_seq
    import lcd_pkg::*;
#(
    parameter int unsigned T_LINK_TO_BL = DEF_T_LINK_TO_BL,
    parameter int unsigned T_BL_TO_LINK = DEF_T_BL_TO_LINK,
    parameter int unsigned T_MIN_OFF    = DEF_T_MIN_OFF,
    parameter int unsigned PWM_PRESCALE = DEF_PWM_PRESCALE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       panel_on,
    input  logic       pll_locked,
    input  logic [7:0] brightness,
    output logic       video_en,
    output logic       led_en,
    output logic       led_pwm,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
);

    seq_state_e  r_state;
    logic [31:0] r_timer;
    logic        r_fault;
    logic        r_video_en;
    logic        r_led_en;
    logic        r_ready;

    seq_state_e  w_state_d;
    logic [31:0] w_timer_d;
    logic        w_fault_d;
    logic        w_lock_lost;
    logic        w_run;

    always_comb begin
        w_state_d   = r_state;
        w_fault_d   = r_fault;
        w_lock_lost = !pll_locked &&
                      (r_state inside {StLinkUp, StOn, StBlDown});

        // Lock loss outranks any request change in the same cycle.
        if (w_lock_lost) begin
            w_state_d = StLinkDown;
            w_fault_d = 1'b1;
        end else begin
            unique case (r_state)
                StOff: begin
                    if (!panel_on) begin
                        w_fault_d = 1'b0;
                    end else if (!r_fault) begin
                        w_state_d = StWaitLock;
                    end
                end
                StWaitLock: begin
                    if (!panel_on) begin
                        w_state_d = StOff;
                    end else if (pll_locked) begin
                        w_state_d = StLinkUp;
                    end
                end
                StLinkUp: begin
                    // Backlight was never on, so skip BL_DOWN.
                    if (!panel_on) begin
                        w_state_d = StLinkDown;
                    end else if (r_timer == 32'd0) begin
                        w_state_d = StOn;
                    end
                end
                StOn: begin
                    if (!panel_on) begin
                        w_state_d = StBlDown;
                    end
                end
                StBlDown: begin
                    if (r_timer == 32'd0) begin
                        w_state_d = StLinkDown;
                    end
                end
                StLinkDown: begin
                    if (r_timer == 32'd0) begin
                        w_state_d = StOff;
                    end
                end
                default: begin
                    w_state_d = StOff;
                end
            endcase
        end

        // Timer is loaded on entry to a timed state and counts down to 0.
        w_timer_d = 32'd0;
        if (w_state_d != r_state) begin
            unique case (w_state_d)
                StLinkUp:   w_timer_d = timer_load(T_LINK_TO_BL);
                StBlDown:   w_timer_d = timer_load(T_BL_TO_LINK);
                StLinkDown: w_timer_d = timer_load(T_MIN_OFF);
                default:    w_timer_d = 32'd0;
            endcase
        end else if (r_timer != 32'd0) begin
            w_timer_d = r_timer - 32'd1;
        end
    end

    // Outputs are registered from the next state so they change together with
    // the state register, one cycle after the causing input.
    assign w_run = (w_state_d == StOn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StOff;
            r_timer    <= 32'd0;
            r_fault    <= 1'b0;
            r_video_en <= 1'b0;
            r_led_en   <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_timer    <= w_timer_d;
            r_fault    <= w_fault_d;
            r_video_en <= (w_state_d inside {StLinkUp, StOn, StBlDown});
            r_led_en   <= w_run;
            r_ready    <= w_run;
        end
    end

    bl_pwm #(
        .PWM_PRESCALE (PWM_PRESCALE)
    ) u_bl_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (w_run),
        .brightness (brightness),
        .pwm_out    (led_pwm)
    );

    assign video_en = r_video_en;
    assign led_en   = r_led_en;
    assign ready    = r_ready;
    assign fault    = r_fault;
    assign state    = r_state;

endmodule

// File: tb/tb_panel_power_seq.sv
// ----------------------------------------------------------------------------
// tb_panel_power_seq
// Directed bench for panel_power_seq with short timing parameters
// (10/10/20 cycles, PWM prescale 2). Observed vector layout:
// {video_en, led_en, led_pwm, ready, fault, state[2:0]}.
// ----------------------------------------------------------------------------
module tb_panel_power_seq;

    logic       clk;
    logic       rst_n;
    logic       panel_on;
    logic       pll_locked;
    logic [7:0] brightness;
    logic       video_en;
    logic       led_en;
    logic       led_pwm;
    logic       ready;
    logic       fault;
    logic [2:0] state;

    int n_pass;
    int n_total;

    panel_power_seq #(
        .T_LINK_TO_BL (10),
        .T_BL_TO_LINK (10),
        .T_MIN_OFF    (20),
        .PWM_PRESCALE (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .panel_on   (panel_on),
        .pll_locked (pll_locked),
        .brightness (brightness),
        .video_en   (video_en),
        .led_en     (led_en),
        .led_pwm    (led_pwm),
        .ready      (ready),
        .fault      (fault),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {video_en, led_en, led_pwm, ready, fault, state};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        panel_on   = 1'b0;
        pll_locked = 1'b1;
        brightness = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reset, request power with the given brightness, and stop in the first
    // ON cycle (t0+12).
    task automatic go_on(input logic [7:0] bright);
        do_reset();
        brightness = bright;
        panel_on   = 1'b1;
        pll_locked = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst_n      = 1'b0;
        panel_on   = 1'b0;
        pll_locked = 1'b0;
        brightness = 8'd0;
        #2;
        e = 8'b0_0_0_0_0_000;
        n_total++;
        if (obs() !== e) $display("FAIL reset_hold: got %b expected %b", obs(), e);
        else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if (obs() !== e) $display("FAIL reset_release: got %b expected %b", obs(), e);
        else n_pass++;
    endtask

    task automatic test_wait_lock();
        logic [7:0] e;
        do_reset();
        pll_locked = 1'b0;
        panel_on   = 1'b1;
        tick();
        e = 8'b0_0_0_0_0_001;
        n_total++;
        if (obs() !== e) $display("FAIL wl_enter: got %b expected %b", obs(), e);
        else n_pass++;
        repeat (3) tick();
        n_total++;
        if (obs() !== e) $display("FAIL wl_hold: got %b expected %b", obs(), e);
        else n_pass++;
        panel_on = 1'b0;
        tick();
        e = 8'b0_0_0_0_0_000;
        n_total++;
        if (obs() !== e) $display("FAIL wl_abort: got %b expected %b", obs(), e);
        else n_pass++;
        panel_on   = 1'b1;
        pll_locked = 1'b1;
        tick();
        tick();
        e = 8'b1_0_0_0_0_010;
        n_total++;
        if (obs() !== e) $display("FAIL wl_linkup: got %b expected %b", obs(), e);
        else n_pass++;
        // Request dropped in LINK_UP goes straight to LINK_DOWN.
        panel_on = 1'b0;
        tick();
        e = 8'b0_0_0_0_0_101;
        n_total++;
        if (obs() !== e) $display("FAIL linkup_abort: got %b expected %b", obs(), e);
        else n_pass++;
    endtask

    task automatic test_power_up();
        logic [7:0] e;
        do_reset();
        panel_on   = 1'b1;   // t0
        pll_locked = 1'b1;
        tick();              // t0+1
        e = 8'b0_0_0_0_0_001;
        n_total++;
        if (obs() !== e) $display("FAIL pu_t1: got %b expected %b", obs(), e);
        else n_pass++;
        tick();              // t0+2
        e = 8'b1_0_0_0_0_010;
        n_total++;
        if (obs() !== e) $display("FAIL pu_video_rise: got %b expected %b", obs(), e);
        else n_pass++;
        repeat (9) tick();   // t0+11
        n_total++;
        if (obs() !== e) $display("FAIL pu_t11: got %b expected %b", obs(), e);
        else n_pass++;
        tick();              // t0+12
        e = 8'b1_1_0_1_0_011;
        n_total++;
        if (obs() !== e) $display("FAIL pu_led_rise: got %b expected %b", obs(), e);
        else n_pass++;
    endtask

    task automatic test_power_down();
        logic [7:0] e;
        go_on(8'd0);
        panel_on = 1'b0;     // d
        tick();              // d+1
        e = 8'b1_0_0_0_0_100;
        n_total++;
        if (obs() !== e) $display("FAIL pd_led_drop: got %b expected %b", obs(), e);
        else n_pass++;
        repeat (9) tick();   // d+10
        n_total++;
        if (obs() !== e) $display("FAIL pd_bl_hold: got %b expected %b", obs(), e);
        else n_pass++;
        tick();              // d+11
        e = 8'b0_0_0_0_0_101;
        n_total++;
        if (obs() !== e) $display("FAIL pd_video_drop: got %b expected %b", obs(), e);
        else n_pass++;
        panel_on = 1'b1;     // must be ignored during LINK_DOWN
        repeat (19) tick();  // d+30
        n_total++;
        if (obs() !== e) $display("FAIL pd_min_off: got %b expected %b", obs(), e);
        else n_pass++;
        tick();              // d+31
        e = 8'b0_0_0_0_0_000;
        n_total++;
        if (obs() !== e) $display("FAIL pd_off: got %b expected %b", obs(), e);
        else n_pass++;
        tick();              // d+32
        e = 8'b0_0_0_0_0_001;
        n_total++;
        if (obs() !== e) $display("FAIL pd_restart: got %b expected %b", obs(), e);
        else n_pass++;
    endtask

    task automatic test_pwm();
        int hi0;
        int hi1;
        int first_low;
        hi0       = 0;
        hi1       = 0;
        first_low = -1;
        go_on(8'd64);
        for (int k = 0; k < 1024; k++) begin
            if (k < 512) hi0 += int'(led_pwm);
            else hi1 += int'(led_pwm);
            if (first_low < 0 && led_pwm === 1'b0) first_low = k;
            if (k == 200) brightness = 8'd192;
            tick();
        end
        n_total++;
        if (hi0 !== 128) $display("FAIL pwm_64_high: got %0d expected %0d", hi0, 128);
        else n_pass++;
        n_total++;
        if (first_low !== 128) $display("FAIL pwm_64_edge: got %0d expected %0d", first_low, 128);
        else n_pass++;
        n_total++;
        if (hi1 !== 384) $display("FAIL pwm_192_high: got %0d expected %0d", hi1, 384);
        else n_pass++;
    endtask

    task automatic test_limits();
        int hi;
        go_on(8'd0);
        hi = 0;
        for (int k = 0; k < 512; k++) begin
            hi += int'(led_pwm);
            tick();
        end
        n_total++;
        if (hi !== 0) $display("FAIL pwm_zero: got %0d expected %0d", hi, 0);
        else n_pass++;
        go_on(8'd255);
        hi = 0;
        for (int k = 0; k < 512; k++) begin
            hi += int'(led_pwm);
            tick();
        end
        n_total++;
        if (hi !== 510) $display("FAIL pwm_full: got %0d expected %0d", hi, 510);
        else n_pass++;
    endtask

    task automatic test_lock_loss();
        logic [7:0] e;
        go_on(8'd255);
        pll_locked = 1'b0;
        tick();
        e = 8'b0_0_0_0_1_101;
        n_total++;
        if (obs() !== e) $display("FAIL ll_drop: got %b expected %b", obs(), e);
        else n_pass++;
        pll_locked = 1'b1;
        repeat (20) tick();
        e = 8'b0_0_0_0_1_000;
        n_total++;
        if (obs() !== e) $display("FAIL ll_off_fault: got %b expected %b", obs(), e);
        else n_pass++;
        repeat (3) tick();   // panel_on still 1: fault keeps us in OFF
        n_total++;
        if (obs() !== e) $display("FAIL ll_fault_hold: got %b expected %b", obs(), e);
        else n_pass++;
        panel_on = 1'b0;
        tick();
        e = 8'b0_0_0_0_0_000;
        n_total++;
        if (obs() !== e) $display("FAIL ll_fault_clear: got %b expected %b", obs(), e);
        else n_pass++;
        panel_on = 1'b1;
        tick();
        e = 8'b0_0_0_0_0_001;
        n_total++;
        if (obs() !== e) $display("FAIL ll_restart: got %b expected %b", obs(), e);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] e;
        go_on(8'd0);
        pll_locked = 1'b0;
        panel_on   = 1'b0;
        tick();
        e = 8'b0_0_0_0_1_101;
        n_total++;
        if (obs() !== e) $display("FAIL lock_priority: got %b expected %b", obs(), e);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        do_reset();
        panel_on   = 1'b1;
        pll_locked = 1'b1;
        repeat (5) tick();
        e = 8'b1_0_0_0_0_010;
        n_total++;
        if (obs() !== e) $display("FAIL rm_linkup: got %b expected %b", obs(), e);
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        e = 8'b0_0_0_0_0_000;
        n_total++;
        if (obs() !== e) $display("FAIL rm_async: got %b expected %b", obs(), e);
        else n_pass++;
        tick();
        rst_n = 1'b1;        // r0, panel_on still 1
        tick();
        tick();              // r0+2
        e = 8'b1_0_0_0_0_010;
        n_total++;
        if (obs() !== e) $display("FAIL rm_relink: got %b expected %b", obs(), e);
        else n_pass++;
        repeat (10) tick();  // r0+12
        e = 8'b1_1_0_1_0_011;
        n_total++;
        if (obs() !== e) $display("FAIL rm_on: got %b expected %b", obs(), e);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_wait_lock();
        test_power_up();
        test_power_down();
        test_pwm();
        test_limits();
        test_lock_loss();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
